// File: rtl/peripheral_system_led_sequencer.sv
// LED pattern sequencer and PIO write arbiter: steps walk/bounce/count/static
// patterns at a programmable dwell and merges host override writes (host first).
module peripheral_system_led_sequencer #(
  parameter int LED_W   = 8,
  parameter int DWELL_W = 24
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic [1:0]         mode,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [LED_W-1:0]   static_pattern,
  input  logic               host_wr_valid,
  input  logic [LED_W-1:0]   host_wr_data,
  output logic               host_wr_ack,
  output logic [1:0]         pio_address,
  output logic               pio_chipselect,
  output logic               pio_write_n,
  output logic [31:0]        pio_writedata,
  output logic [LED_W-1:0]   cur_pattern,
  output logic               busy,
  output logic [1:0]         dbg_state
);

  // host_wr_valid is a one-cycle request with no back-pressure; host_wr_ack
  // pulses in the cycle that data is on the PIO bus; a newer request replaces an unissued one.
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WRITE = 2'd1, S_WAIT = 2'd2, S_HOST_WR = 2'd3} state_e;

  localparam logic [1:0]       MODE_WALK   = 2'd0;
  localparam logic [1:0]       MODE_BOUNCE = 2'd1;
  localparam logic [1:0]       MODE_COUNT  = 2'd2;
  localparam logic [LED_W-1:0] ONE         = LED_W'(1);
  localparam logic [LED_W-1:0] MSB         = {1'b1, {(LED_W-1){1'b0}}};

  state_e             state_q, state_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [LED_W-1:0]   pattern_q, pattern_d;
  logic               dir_up_q, dir_up_d;
  logic               pend_q, pend_d;
  logic [LED_W-1:0]   pend_data_q, pend_data_d;
  logic               cs_q, cs_d;
  logic               ack_q, ack_d;
  logic               busy_q, busy_d;
  logic               host_go;
  logic [LED_W-1:0]   host_data;

  // Returns {dir_up, pattern} for the step following pattern p.
  function automatic logic [LED_W:0] next_step(input logic [1:0] m, input logic [LED_W-1:0] p,
                                               input logic up, input logic [LED_W-1:0] sp);
    logic [LED_W-1:0] t;
    next_step = {up, p};
    t = '0;
    case (m)
      MODE_WALK: next_step = {up, (p == '0) ? ONE : {p[LED_W-2:0], p[LED_W-1]}};
      MODE_BOUNCE: begin
        if (up) begin
          t = p << 1;
          if (p == MSB)      next_step = {1'b0, MSB >> 1};
          else if (t == '0)  next_step = {1'b1, ONE};
          else               next_step = {1'b1, t};
        end else begin
          t = p >> 1;
          if (p == ONE)      next_step = {1'b1, ONE << 1};
          else if (t == '0)  next_step = {1'b1, ONE};
          else               next_step = {1'b0, t};
        end
      end
      MODE_COUNT: next_step = {up, p + ONE};
      default:    next_step = {up, sp};
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      pattern_q   <= '0;
      dir_up_q    <= 1'b1;
      pend_q      <= 1'b0;
      pend_data_q <= '0;
      cs_q        <= 1'b0;
      ack_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pattern_q   <= pattern_d;
      dir_up_q    <= dir_up_d;
      pend_q      <= pend_d;
      pend_data_q <= pend_data_d;
      cs_q        <= cs_d;
      ack_q       <= ack_d;
      busy_q      <= busy_d;
    end
  end

  // A request arriving this cycle counts as pending so it can beat a same-cycle step.
  assign host_go   = host_wr_valid | pend_q;
  assign host_data = host_wr_valid ? host_wr_data : pend_data_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pattern_d   = pattern_q;
    dir_up_d    = dir_up_q;
    pend_d      = pend_q;
    pend_data_d = pend_data_q;
    case (state_q)
      S_IDLE: begin
        if (host_go) begin
          state_d = S_HOST_WR;
        end else if (enable) begin
          state_d  = S_WRITE;
          dir_up_d = 1'b1;
          case (mode)
            MODE_COUNT:  pattern_d = '0;
            2'd3:        pattern_d = static_pattern;
            default:     pattern_d = ONE;
          endcase
        end
      end
      S_WRITE: begin
        if (host_go) begin
          state_d = S_HOST_WR;
        end else if (enable) begin
          state_d = S_WAIT;
          cnt_d   = dwell;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (host_go) begin
          state_d = S_HOST_WR;
        end else if (!enable) begin
          state_d = S_IDLE;
        end else if (cnt_q == '0) begin
          state_d               = S_WRITE;
          {dir_up_d, pattern_d} = next_step(mode, pattern_q, dir_up_q, static_pattern);
        end else begin
          cnt_d = cnt_q - DWELL_W'(1);
        end
      end
      default: begin
        if (enable) begin
          state_d = S_WAIT;
          cnt_d   = dwell;
        end else begin
          state_d = S_IDLE;
        end
      end
    endcase
    if (state_d == S_HOST_WR) begin
      pattern_d = host_data;
      pend_d    = 1'b0;
    end else if (host_wr_valid) begin
      pend_d      = 1'b1;
      pend_data_d = host_wr_data;
    end
  end

  always_comb begin
    cs_d   = (state_d == S_WRITE) || (state_d == S_HOST_WR);
    ack_d  = (state_d == S_HOST_WR);
    busy_d = (state_d != S_IDLE);
  end

  assign pio_address    = 2'b00;
  assign pio_chipselect = cs_q;
  assign pio_write_n    = ~cs_q;
  assign pio_writedata  = {{(32-LED_W){1'b0}}, pattern_q};
  assign cur_pattern    = pattern_q;
  assign host_wr_ack    = ack_q;
  assign busy           = busy_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_peripheral_system_led_sequencer.sv
// Bench for peripheral_system_led_sequencer: directed pattern/override scenarios
// plus randomized traffic, all checked against a behavioural model.
module tb_peripheral_system_led_sequencer;

  logic        clk;
  logic        reset;
  logic        enable;
  logic [1:0]  mode;
  logic [23:0] dwell;
  logic [7:0]  static_pattern;
  logic        host_wr_valid;
  logic [7:0]  host_wr_data;
  logic        host_wr_ack;
  logic [1:0]  pio_address;
  logic        pio_chipselect;
  logic        pio_write_n;
  logic [31:0] pio_writedata;
  logic [7:0]  cur_pattern;
  logic        busy;
  logic [1:0]  dbg_state;

  peripheral_system_led_sequencer #(.LED_W(8), .DWELL_W(24)) dut (
    .clk(clk), .reset(reset), .enable(enable), .mode(mode), .dwell(dwell),
    .static_pattern(static_pattern), .host_wr_valid(host_wr_valid),
    .host_wr_data(host_wr_data), .host_wr_ack(host_wr_ack),
    .pio_address(pio_address), .pio_chipselect(pio_chipselect),
    .pio_write_n(pio_write_n), .pio_writedata(pio_writedata),
    .cur_pattern(cur_pattern), .busy(busy), .dbg_state(dbg_state)
  );

  // clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int ack_cnt  = 0;
  logic [7:0] exp_q[$];
  int         log_data[$];
  int         log_cyc[$];

  // staged inputs for the next cycle
  logic        n_reset = 1'b1, n_en = 1'b0, n_hv = 1'b0;
  logic [1:0]  n_mode = 2'd0;
  logic [23:0] n_dwell = 24'd0;
  logic [7:0]  n_sp = 8'd0, n_hd = 8'd0;

  // model: m_strobe 0 none, 1 sequencer write, 2 host write (for the current cycle)
  int m_strobe, m_running, m_left, m_pat, m_up, m_pend, m_pend_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_advance();
    case (mode)
      2'd0: m_pat = (m_pat == 0) ? 1 : ((m_pat * 2) % 256) + (m_pat / 128);
      2'd1: begin
        if (m_up != 0) begin
          if (m_pat == 128) begin m_up = 0; m_pat = 64; end
          else begin
            m_pat = (m_pat * 2) % 256;
            if (m_pat == 0) begin m_pat = 1; m_up = 1; end
          end
        end else begin
          if (m_pat == 1) begin m_up = 1; m_pat = 2; end
          else begin
            m_pat = m_pat / 2;
            if (m_pat == 0) begin m_pat = 1; m_up = 1; end
          end
        end
      end
      2'd2: m_pat = (m_pat + 1) % 256;
      default: m_pat = int'(static_pattern);
    endcase
  endtask

  task automatic model_update();
    int hgo, hdat, ns;
    if (reset) begin
      m_strobe = 0; m_running = 0; m_left = 0; m_pat = 0; m_up = 1;
      m_pend = 0; m_pend_data = 0;
      exp_q.delete();
      return;
    end
    hgo  = (host_wr_valid || m_pend != 0) ? 1 : 0;
    hdat = host_wr_valid ? int'(host_wr_data) : m_pend_data;
    ns   = 0;
    if (m_strobe == 2) begin
      m_running = enable ? 1 : 0;
      m_left    = int'(dwell);
    end else if (hgo != 0) begin
      ns = 2;
    end else if (m_running == 0) begin
      if (enable) begin
        m_up = 1;
        m_pat = (mode == 2'd2) ? 0 : (mode == 2'd3) ? int'(static_pattern) : 1;
        m_running = 1;
        ns = 1;
      end
    end else if (m_strobe == 1) begin
      if (enable) m_left = int'(dwell);
      else m_running = 0;
    end else begin
      if (!enable) m_running = 0;
      else if (m_left == 0) begin model_advance(); ns = 1; end
      else m_left--;
    end
    if (ns == 2) begin
      m_pat = hdat; m_pend = 0;
    end else if (host_wr_valid) begin
      m_pend = 1; m_pend_data = int'(host_wr_data);
    end
    m_strobe = ns;
    if (ns != 0) exp_q.push_back(8'(m_pat));
  endtask

  // observe the current cycle at the falling edge, then drive the next inputs
  task automatic step();
    logic       bexp;
    logic [7:0] e;
    @(negedge clk);
    cyc++;
    bexp = (m_strobe != 0) || (m_running != 0);
    chk("chipselect", pio_chipselect, m_strobe != 0);
    chk("write_n", pio_write_n, m_strobe == 0);
    chk("ack", host_wr_ack, m_strobe == 2);
    chk("busy", busy, bexp);
    chk("dbg_idle", dbg_state == 2'd0, !bexp);
    chk("cur_pattern", cur_pattern, m_pat);
    chk("address", pio_address, 0);
    chk("wdata_hi", pio_writedata[31:8], 0);
    if (m_strobe != 0) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
      chk("writedata", pio_writedata, {24'h0, e});
    end
    if (pio_chipselect && !pio_write_n) begin
      log_data.push_back(int'(pio_writedata[7:0]));
      log_cyc.push_back(cyc);
    end
    if (host_wr_ack) ack_cnt++;
    reset = n_reset; enable = n_en; mode = n_mode; dwell = n_dwell;
    static_pattern = n_sp; host_wr_valid = n_hv; host_wr_data = n_hd;
    model_update();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic clear_log();
    log_data.delete(); log_cyc.delete(); ack_cnt = 0;
  endtask

  task automatic wait_strobes(input int k, input int budget);
    int n = 0;
    while (log_data.size() < k && n < budget) begin step(); n++; end
    if (log_data.size() < k) chk("strobe_timeout", log_data.size(), k);
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; mode = 2'd0; dwell = 24'd0;
    static_pattern = 8'd0; host_wr_valid = 1'b0; host_wr_data = 8'd0;
    model_update();
    run(2);

    // walk, dwell 2: 01..80,01 every 4 cycles
    n_reset = 1'b0; n_en = 1'b1; n_mode = 2'd0; n_dwell = 24'd2;
    clear_log();
    wait_strobes(9, 60);
    for (int i = 0; i < 9; i++) begin
      chk("walk_data", log_data[i], (i < 8) ? (1 << i) : 1);
      if (i > 0) chk("walk_period", log_cyc[i] - log_cyc[i-1], 4);
    end

    // reset in the middle of WAIT
    step();
    n_reset = 1'b1; step();
    n_reset = 1'b0; n_en = 1'b0; step();
    chk("rst_cs", pio_chipselect, 0);
    chk("rst_wr_n", pio_write_n, 1);
    chk("rst_cur", cur_pattern, 0);
    chk("rst_busy", busy, 0);

    // bounce, dwell 0
    n_mode = 2'd1; n_dwell = 24'd0; n_en = 1'b1;
    clear_log();
    wait_strobes(16, 60);
    for (int i = 0; i < 16; i++) begin
      chk("bounce_data", log_data[i], (i <= 7) ? (1 << i) : (i <= 14) ? (1 << (14 - i)) : 2);
      if (i > 0) chk("bounce_period", log_cyc[i] - log_cyc[i-1], 2);
    end
    n_en = 1'b0; run(3);

    // count wrap via host seed FE
    n_mode = 2'd2; n_dwell = 24'd1; n_en = 1'b1;
    clear_log();
    wait_strobes(1, 20);
    chk("count_seed", log_data[0], 0);
    clear_log();
    n_hv = 1'b1; n_hd = 8'hFE; step(); n_hv = 1'b0;
    wait_strobes(3, 30);
    chk("count_fe", log_data[0], 8'hFE);
    chk("count_ff", log_data[1], 8'hFF);
    chk("count_00", log_data[2], 8'h00);
    chk("count_period", log_cyc[2] - log_cyc[1], 3);

    // host override in the cnt==0 cycle beats the walk step
    n_en = 1'b0; n_reset = 1'b1; step();
    n_reset = 1'b0; n_mode = 2'd0; n_dwell = 24'd3; n_en = 1'b1;
    clear_log();
    wait_strobes(3, 40);
    run(3);
    n_hv = 1'b1; n_hd = 8'hA5; step(); n_hv = 1'b0;
    wait_strobes(5, 40);
    chk("ovr_walk04", log_data[2], 8'h04);
    chk("ovr_a5", log_data[3], 8'hA5);
    chk("ovr_a5_slot", log_cyc[3] - log_cyc[2], 5);
    chk("ovr_4b", log_data[4], 8'h4B);
    chk("ovr_4b_slot", log_cyc[4] - log_cyc[3], 5);
    chk("ovr_ack_once", ack_cnt, 1);

    // enable drops in WAIT
    step();
    n_en = 1'b0; step();
    step();
    chk("busy_fall", busy, 0);
    clear_log();
    run(15);
    chk("stop_no_strobe", log_data.size(), 0);
    chk("stop_hold", cur_pattern, 8'h4B);

    // back-to-back host requests while idle
    n_hv = 1'b1; n_hd = 8'h11; step();
    n_hd = 8'h22; step();
    n_hv = 1'b0; run(6);
    chk("b2b_count_ok", (log_data.size() >= 1) && (log_data.size() <= 2), 1);
    chk("b2b_last", log_data[log_data.size() - 1], 8'h22);
    chk("b2b_cur", cur_pattern, 8'h22);

    // randomized traffic
    n_en = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      n_reset = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 40) == 0) n_en = ~n_en;
      if ($urandom_range(0, 31) == 0) n_mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) n_dwell = 24'($urandom_range(0, 4));
      n_sp = 8'($urandom_range(0, 255));
      n_hv = ($urandom_range(0, 9) == 0);
      n_hd = 8'($urandom_range(0, 255));
      step();
    end
    n_hv = 1'b0; n_reset = 1'b0;
    run(4);

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule
